// File: rtl/l1_tags_ctl.sv
// l1_tags_ctl: front-end sequencer/arbiter for one L1 tags array.
//
// Shares the tags array's access, invalidate and clear request/ack channels
// between the CPU access port, a small FIFO of coherence invalidations and
// maintenance clear requests. Only one tags request is outstanding at a time.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   S_IDLE  | no tags request outstanding; grants are decided here
//   S_ACC   | CPU access issued on the access channel, awaiting ack
//   S_INV   | FIFO-head invalidation issued, awaiting ack
//   S_CLR   | full tags clear issued, awaiting ack
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   i_cpu_*/o_cpu_*           CPU access request and completion
//   i_inv_push/i_inv_adr      invalidation enqueue; o_inv_full back-pressure
//   i_clr_req                 clear request pulse; o_clr_busy, o_clr_done
//   o_tag_*/i_tag_*           tags array request/ack channels
//
// Optional build macro L1_TAGS_CTL_STATS_EN adds o_stat_acc, o_stat_hit and
// o_stat_inv: wrapping counts of CPU acks, CPU hit acks and invalidation acks.

module l1_tags_ctl #(
  parameter int INV_FIFO_DEPTH_LOG2 = 2,
  parameter int INV_STARVE_LIMIT    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_cpu_req,
  input  logic [31:0] i_cpu_adr,
  input  logic        i_cpu_wen,
  output logic        o_cpu_ack,
  output logic        o_cpu_hit,
  output logic        o_cpu_way,
  input  logic        i_inv_push,
  input  logic [31:0] i_inv_adr,
  output logic        o_inv_full,
  input  logic        i_clr_req,
  output logic        o_clr_busy,
  output logic        o_clr_done,
  output logic        o_tag_acc_req,
  output logic [31:0] o_tag_acc_adr,
  output logic        o_tag_acc_wen,
  input  logic        i_tag_acc_ack,
  input  logic        i_tag_acc_hit,
  input  logic        i_tag_acc_way,
  output logic        o_tag_inv_req,
  output logic [31:0] o_tag_inv_adr,
  input  logic        i_tag_inv_ack,
  output logic        o_tag_clr_req,
  input  logic        i_tag_clr_ack
`ifdef L1_TAGS_CTL_STATS_EN
  ,
  output logic [31:0] o_stat_acc,
  output logic [31:0] o_stat_hit,
  output logic [31:0] o_stat_inv
`endif
);

  localparam int PW    = INV_FIFO_DEPTH_LOG2;
  localparam int CW    = INV_FIFO_DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << INV_FIFO_DEPTH_LOG2;
  localparam logic [PW-1:0] PTR_ONE    = 1;
  localparam logic [CW-1:0] CNT_FULL   = CW'(DEPTH);
  localparam logic [3:0]    STARVE_MAX = 4'(INV_STARVE_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_INV, S_CLR} state_t;

  state_t        state_q, state_d;
  logic          grant_acc, grant_inv, grant_clr;
  logic          clr_pending_q, clr_want;
  logic [3:0]    starve_q;
  logic [31:0]   acc_adr_q, inv_adr_q;
  logic          acc_wen_q;

  logic [31:0]   fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          inv_full_q, fifo_empty, push_ok;

  assign fifo_empty = (cnt_q == '0);
  assign push_ok    = i_inv_push & ~inv_full_q;
  // A clear pulse arriving in Idle is granted immediately rather than
  // waiting a cycle in clr_pending behind a CPU request.
  assign clr_want   = clr_pending_q | i_clr_req;

  always_comb begin
    state_d   = state_q;
    grant_acc = 1'b0;
    grant_inv = 1'b0;
    grant_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clr_want) begin
          grant_clr = 1'b1;
          state_d   = S_CLR;
        end else if (!fifo_empty && starve_q == STARVE_MAX) begin
          grant_inv = 1'b1;
          state_d   = S_INV;
        end else if (i_cpu_req) begin
          grant_acc = 1'b1;
          state_d   = S_ACC;
        end else if (!fifo_empty) begin
          grant_inv = 1'b1;
          state_d   = S_INV;
        end
      end
      S_ACC:   if (i_tag_acc_ack) state_d = S_IDLE;
      S_INV:   if (i_tag_inv_ack) state_d = S_IDLE;
      S_CLR:   if (i_tag_clr_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Clear flushes queued entries; a push landing in the same cycle survives.
  always_comb begin
    if (grant_clr) cnt_d = push_ok ? CW'(1) : '0;
    else           cnt_d = cnt_q + CW'(push_ok) - CW'(grant_inv);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      clr_pending_q <= 1'b0;
      starve_q      <= '0;
      acc_adr_q     <= '0;
      acc_wen_q     <= 1'b0;
      inv_adr_q     <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      inv_full_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inv_full_q <= (cnt_d == CNT_FULL);
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (grant_clr)      rd_ptr_q <= wr_ptr_q;
      else if (grant_inv) rd_ptr_q <= rd_ptr_q + PTR_ONE;

      if (grant_clr)                          clr_pending_q <= 1'b0;
      else if (i_clr_req && state_q != S_CLR) clr_pending_q <= 1'b1;

      if (fifo_empty || grant_inv)              starve_q <= '0;
      else if (grant_acc && starve_q != STARVE_MAX) starve_q <= starve_q + 4'd1;

      if (grant_acc) begin
        acc_adr_q <= i_cpu_adr;
        acc_wen_q <= i_cpu_wen;
      end
      if (grant_inv) inv_adr_q <= fifo_mem[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= i_inv_adr;
  end

  assign o_tag_acc_req = (state_q == S_ACC);
  assign o_tag_acc_adr = acc_adr_q;
  assign o_tag_acc_wen = acc_wen_q;
  assign o_tag_inv_req = (state_q == S_INV);
  assign o_tag_inv_adr = inv_adr_q;
  assign o_tag_clr_req = (state_q == S_CLR);

  assign o_cpu_ack  = (state_q == S_ACC) & i_tag_acc_ack;
  assign o_cpu_hit  = o_cpu_ack & i_tag_acc_hit;
  assign o_cpu_way  = o_cpu_ack & i_tag_acc_way;
  assign o_inv_full = inv_full_q;
  assign o_clr_busy = clr_pending_q | (state_q == S_CLR);
  assign o_clr_done = (state_q == S_CLR) & i_tag_clr_ack;

`ifdef L1_TAGS_CTL_STATS_EN
  logic [31:0] stat_acc_q, stat_hit_q, stat_inv_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_acc_q <= '0;
      stat_hit_q <= '0;
      stat_inv_q <= '0;
    end else begin
      if (o_cpu_ack) stat_acc_q <= stat_acc_q + 32'd1;
      if (o_cpu_hit) stat_hit_q <= stat_hit_q + 32'd1;
      if (state_q == S_INV && i_tag_inv_ack) stat_inv_q <= stat_inv_q + 32'd1;
    end
  end

  assign o_stat_acc = stat_acc_q;
  assign o_stat_hit = stat_hit_q;
  assign o_stat_inv = stat_inv_q;
`endif

endmodule

// File: tb/tb_l1_tags_ctl.sv
// Directed bench for l1_tags_ctl with default parameters (4-entry FIFO,
// starvation limit 4). Inputs change just after the falling edge; outputs are
// sampled 1ns later, well away from the rising edge.

module tb_l1_tags_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_wen, inv_push, clr_req;
  logic [31:0] cpu_adr, inv_adr_in;
  logic        cpu_ack, cpu_hit, cpu_way, inv_full, clr_busy, clr_done;
  logic        tag_acc_req, tag_acc_wen, tag_inv_req, tag_clr_req;
  logic [31:0] tag_acc_adr, tag_inv_adr;
  logic        acc_ack, acc_hit, acc_way, inv_ack, clr_ack;
`ifdef L1_TAGS_CTL_STATS_EN
  logic [31:0] stat_acc, stat_hit, stat_inv;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  l1_tags_ctl dut (
    .clk           (clk),
    .rst           (rst),
    .i_cpu_req     (cpu_req),
    .i_cpu_adr     (cpu_adr),
    .i_cpu_wen     (cpu_wen),
    .o_cpu_ack     (cpu_ack),
    .o_cpu_hit     (cpu_hit),
    .o_cpu_way     (cpu_way),
    .i_inv_push    (inv_push),
    .i_inv_adr     (inv_adr_in),
    .o_inv_full    (inv_full),
    .i_clr_req     (clr_req),
    .o_clr_busy    (clr_busy),
    .o_clr_done    (clr_done),
    .o_tag_acc_req (tag_acc_req),
    .o_tag_acc_adr (tag_acc_adr),
    .o_tag_acc_wen (tag_acc_wen),
    .i_tag_acc_ack (acc_ack),
    .i_tag_acc_hit (acc_hit),
    .i_tag_acc_way (acc_way),
    .o_tag_inv_req (tag_inv_req),
    .o_tag_inv_adr (tag_inv_adr),
    .i_tag_inv_ack (inv_ack),
    .o_tag_clr_req (tag_clr_req),
    .i_tag_clr_ack (clr_ack)
`ifdef L1_TAGS_CTL_STATS_EN
    ,
    .o_stat_acc    (stat_acc),
    .o_stat_hit    (stat_hit),
    .o_stat_inv    (stat_inv)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_acc_req"}, tag_acc_req, 0);
    chk({tag, "_inv_req"}, tag_inv_req, 0);
    chk({tag, "_clr_req"}, tag_clr_req, 0);
    chk({tag, "_cpu_ack"}, cpu_ack, 0);
    chk({tag, "_inv_full"}, inv_full, 0);
    chk({tag, "_clr_busy"}, clr_busy, 0);
    chk({tag, "_clr_done"}, clr_done, 0);
    chk({tag, "_acc_adr"}, tag_acc_adr, 0);
    chk({tag, "_inv_adr"}, tag_inv_adr, 0);
  endtask

  // Issue one CPU access from Idle, acked in its first request cycle.
  task automatic cpu_access(input logic [31:0] adr, input logic wen,
                            input logic hit, input logic way);
    @(negedge clk); cpu_req = 1; cpu_adr = adr; cpu_wen = wen;
    @(negedge clk); cpu_adr = ~adr; cpu_wen = ~wen;
    acc_ack = 1; acc_hit = hit; acc_way = way; #1;
    chk("acc_req", tag_acc_req, 1);
    chk("acc_adr_held", tag_acc_adr, adr);
    chk("acc_wen_held", tag_acc_wen, wen);
    chk("acc_cpu_ack", cpu_ack, 1);
    chk("acc_cpu_hit", cpu_hit, hit);
    chk("acc_cpu_way", cpu_way, way);
    @(negedge clk); cpu_req = 0; acc_ack = 0; acc_hit = 0; acc_way = 0;
  endtask

  int grants [8];
  int exp_grants [7] = '{1, 1, 1, 1, 1, 2, 1};
  int ng;

  initial begin
    rst = 1; cpu_req = 0; cpu_wen = 0; cpu_adr = 0; inv_push = 0; inv_adr_in = 0;
    clr_req = 0; acc_ack = 0; acc_hit = 0; acc_way = 0; inv_ack = 0; clr_ack = 0;
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk); rst = 0;

    // Basic read: grant at N, request at N+1/N+2, ack at N+2, drop at N+3.
    @(negedge clk); cpu_req = 1; cpu_adr = 32'h0000_1040; cpu_wen = 0; #1;
    chk("t1_req_n0", tag_acc_req, 0);
    @(negedge clk); #1;
    chk("t1_req_n1", tag_acc_req, 1);
    chk("t1_adr", tag_acc_adr, 32'h0000_1040);
    chk("t1_wen", tag_acc_wen, 0);
    chk("t1_noack_n1", cpu_ack, 0);
    @(negedge clk); acc_ack = 1; acc_hit = 1; acc_way = 1; #1;
    chk("t1_req_n2", tag_acc_req, 1);
    chk("t1_ack", cpu_ack, 1);
    chk("t1_hit", cpu_hit, 1);
    chk("t1_way", cpu_way, 1);
    @(negedge clk); cpu_req = 0; acc_ack = 0; acc_hit = 0; acc_way = 0; #1;
    chk("t1_req_n3", tag_acc_req, 0);

    // Stray acks in Idle are ignored.
    @(negedge clk); acc_ack = 1; acc_hit = 1; inv_ack = 1; clr_ack = 1; #1;
    chk("stray_cpu_ack", cpu_ack, 0);
    chk("stray_cpu_hit", cpu_hit, 0);
    chk("stray_clr_done", clr_done, 0);
    @(negedge clk); acc_ack = 0; acc_hit = 0; inv_ack = 0; clr_ack = 0; #1;
    chk("stray_idle", tag_acc_req | tag_inv_req | tag_clr_req, 0);

    // Write access, operands held while the CPU inputs change.
    cpu_access(32'hDEAD_BEE0, 1'b1, 1'b0, 1'b1);

    // Fill the FIFO behind a stalled CPU access, then drain in order.
    @(negedge clk); cpu_req = 1; cpu_adr = 32'h2000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); inv_push = 1; inv_adr_in = 32'h100 * (i + 1);
    end
    @(negedge clk); inv_push = 1; inv_adr_in = 32'h500; #1;
    chk("t2_full", inv_full, 1);
    chk("t2_acc_stall", tag_acc_req, 1);
    @(negedge clk); inv_push = 0; acc_ack = 1; #1;
    chk("t2_full_hold", inv_full, 1);
    chk("t2_cpu_ack", cpu_ack, 1);
    @(negedge clk); cpu_req = 0; acc_ack = 0; #1;
    chk("t2_idle", tag_inv_req, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); inv_ack = 1; #1;
      chk("t2_inv_req", tag_inv_req, 1);
      chk("t2_inv_adr", tag_inv_adr, 32'h100 * (i + 1));
      chk("t2_acc_quiet", tag_acc_req, 0);
      if (i == 0) chk("t2_full_fall", inv_full, 0);
      @(negedge clk); inv_ack = 0; #1;
      chk("t2_inv_gap", tag_inv_req, 0);
    end
    @(negedge clk); #1;
    chk("t2_fifth_dropped", tag_inv_req, 0);

    // Starvation: one queued entry under continuous CPU traffic.
    @(negedge clk); cpu_req = 1; cpu_adr = 32'h3000;
    ng = 0;
    for (int i = 1; i <= 13; i++) begin
      @(negedge clk);
      inv_push = (i == 1); inv_adr_in = 32'hABC;
      acc_ack = tag_acc_req; inv_ack = tag_inv_req; #1;
      chk("t3_onehot", ($countones({tag_acc_req, tag_inv_req, tag_clr_req}) <= 1), 1);
      if (tag_inv_req) chk("t3_inv_adr", tag_inv_adr, 32'hABC);
      if ((tag_acc_req || tag_inv_req) && ng < 8) begin
        grants[ng] = tag_acc_req ? 1 : 2;
        ng++;
      end
    end
    @(negedge clk); cpu_req = 0; acc_ack = 0; inv_ack = 0; inv_push = 0; #1;
    chk("t3_ngrants", ng, 7);
    for (int k = 0; k < 7; k++) chk("t3_grant_order", grants[k], exp_grants[k]);
    chk("t3_idle", tag_acc_req | tag_inv_req, 0);
`ifdef L1_TAGS_CTL_STATS_EN
    chk("stat_inv_mid", stat_inv, 5);
`endif

    // Clear requested while an access is in flight with 3 entries queued.
    @(negedge clk); cpu_req = 1; cpu_adr = 32'h4000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); inv_push = 1; inv_adr_in = 32'h11 * (i + 1);
    end
    @(negedge clk); inv_push = 0; clr_req = 1;
    @(negedge clk); clr_req = 0; acc_ack = 1; #1;
    chk("t4_clr_busy_pend", clr_busy, 1);
    chk("t4_acc_first", cpu_ack, 1);
    @(negedge clk); cpu_req = 0; acc_ack = 0;
    @(negedge clk); #1;
    chk("t4_clr_req", tag_clr_req, 1);
    chk("t4_no_inv", tag_inv_req, 0);
    chk("t4_no_done", clr_done, 0);
    @(negedge clk); clr_ack = 1; #1;
    chk("t4_done", clr_done, 1);
    @(negedge clk); clr_ack = 0; #1;
    chk("t4_done_once", clr_done, 0);
    chk("t4_busy_low", clr_busy, 0);
    @(negedge clk); #1;
    chk("t4_fifo_flushed", tag_inv_req, 0);
    @(negedge clk); #1;
    chk("t4_fifo_flushed2", tag_inv_req, 0);

    // Clear, CPU and a non-empty FIFO together in Idle.
    @(negedge clk); cpu_req = 1; cpu_adr = 32'h5000;
    @(negedge clk); inv_push = 1; inv_adr_in = 32'h55;
    @(negedge clk); inv_push = 0; acc_ack = 1;
    @(negedge clk); acc_ack = 0; clr_req = 1;
    @(negedge clk); clr_req = 0; #1;
    chk("t5_clr_wins", tag_clr_req, 1);
    chk("t5_no_acc", tag_acc_req, 0);
    chk("t5_busy", clr_busy, 1);
    @(negedge clk); clr_req = 1; clr_ack = 1; #1;
    chk("t5_done", clr_done, 1);
    @(negedge clk); clr_req = 0; clr_ack = 0; #1;
    chk("t5_merged", clr_busy, 0);
    @(negedge clk); acc_ack = 1; #1;
    chk("t5_cpu_next", tag_acc_req, 1);
    chk("t5_cpu_adr", tag_acc_adr, 32'h5000);
    @(negedge clk); cpu_req = 0; acc_ack = 0; #1;
    chk("t5_no_extra_clr", tag_clr_req, 0);
    chk("t5_no_inv", tag_inv_req, 0);
    @(negedge clk); #1;
    chk("t5_no_extra_clr2", tag_clr_req, 0);
    chk("t5_no_inv2", tag_inv_req, 0);

    // Reset during AccBusy with an entry queued.
    @(negedge clk); cpu_req = 1; cpu_adr = 32'h6000; inv_push = 1; inv_adr_in = 32'h77;
    @(negedge clk); inv_push = 0; rst = 1; #1;
    chk("t6_in_acc", tag_acc_req, 1);
    @(negedge clk); rst = 0; cpu_req = 0; #1;
    chk_all_zero("t6_rst");
`ifdef L1_TAGS_CTL_STATS_EN
    chk("t6_stat_acc0", stat_acc, 0);
    chk("t6_stat_inv0", stat_inv, 0);
`endif
    @(negedge clk); #1;
    chk("t6_fifo_empty", tag_inv_req, 0);
    @(negedge clk); #1;
    chk("t6_fifo_empty2", tag_inv_req, 0);

    // Ten accesses, seven of them hits.
    for (int i = 0; i < 10; i++)
      cpu_access(32'h7000 + 32'(i * 64), 1'b0, (i < 7), i[0]);
`ifdef L1_TAGS_CTL_STATS_EN
    #1;
    chk("stat_acc", stat_acc, 10);
    chk("stat_hit", stat_hit, 7);
    chk("stat_inv", stat_inv, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
